// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude compare controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmp_pkg;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

    // Result encoding for downstream consumers that prefer a code over one-hot flags.
    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_LT = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;

    // Bit index width; at least one bit so WIDTH=1 still has a legal register.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_cmp_ctrl_if.sv
// Start/done handshake and operand/result bundle for the serial comparator.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while a compare is in flight.
interface serial_mag_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             eq;
    logic             lt;
    logic             gt;

    modport master (
        output start, a, b,
        input  busy, done, eq, lt, gt
    );

    modport slave (
        input  start, a, b,
        output busy, done, eq, lt, gt
    );
endinterface

// File: rtl/serial_mag_cmp_ctrl_cell.sv
// One-bit magnitude comparator cell (x against y).
// Latency: purely combinational.
// Backpressure: none.
module mag_bit_cell (
    input  logic x,
    input  logic y,
    output logic eq,
    output logic lt,
    output logic gt
);
    assign eq = ~(x ^ y);
    assign lt = ~x & y;
    assign gt = x & ~y;
endmodule

// File: rtl/serial_mag_cmp_ctrl.sv
// MSB-first serial magnitude compare of latched operands with early exit.
// Latency: done pulses WIDTH-k+1 cycles after start (k = highest differing bit, 0 if equal).
// Backpressure: start is only sampled in IDLE; requests during SHIFT/DONE are dropped.
module serial_mag_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_mag_cmp_ctrl_if.slave bus
);
    localparam int IDXW = idx_width(WIDTH);
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(WIDTH - 1);

    cmp_state_t       state, state_n;
    logic [WIDTH-1:0] ra, ra_n;
    logic [WIDTH-1:0] rb, rb_n;
    logic [IDXW-1:0]  idx, idx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             eq_q, eq_n;
    logic             lt_q, lt_n;
    logic             gt_q, gt_n;
    logic             cell_eq, cell_lt, cell_gt;

    mag_bit_cell u_cell (
        .x  (ra[idx]),
        .y  (rb[idx]),
        .eq (cell_eq),
        .lt (cell_lt),
        .gt (cell_gt)
    );

    // State, operand, index and result registers; reset aborts any compare in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            eq_q   <= 1'b0;
            lt_q   <= 1'b0;
            gt_q   <= 1'b0;
        end else begin
            state  <= state_n;
            ra     <= ra_n;
            rb     <= rb_n;
            idx    <= idx_n;
            busy_q <= busy_n;
            done_q <= done_n;
            eq_q   <= eq_n;
            lt_q   <= lt_n;
            gt_q   <= gt_n;
        end
    end

    // Next-state logic: accept in IDLE, walk bits down in SHIFT, single-cycle DONE.
    always_comb begin
        state_n = state;
        ra_n    = ra;
        rb_n    = rb;
        idx_n   = idx;
        busy_n  = busy_q;
        done_n  = 1'b0;
        eq_n    = eq_q;
        lt_n    = lt_q;
        gt_n    = gt_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    ra_n    = bus.a;
                    rb_n    = bus.b;
                    idx_n   = IDX_MSB;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    gt_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (cell_gt) begin
                    gt_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else if (cell_lt) begin
                    lt_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else if (cell_eq) begin
                    // idx==0 always exits, so the decrement never wraps.
                    if (idx == '0) begin
                        eq_n    = 1'b1;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n = idx - IDXW'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// Scoreboard bench for the serial magnitude comparator (WIDTH=8 and WIDTH=1 instances).
// Latency: expected done edge is recorded per launch and checked by the monitors.
// Backpressure: exercises start requests issued while a compare is busy or in DONE.
module tb_serial_mag_cmp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned at;
        logic [2:0]  res;  // {eq, lt, gt}
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];

    serial_mag_cmp_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_mag_cmp_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_mag_cmp_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_mag_cmp_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus8.done) begin
            if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done8_unexpected actual=%b required=no_done at edge %0d",
                         {bus8.eq, bus8.lt, bus8.gt}, cyc);
            end else begin
                e = q8.pop_front();
                check("done8_edge", cyc, e.at);
                check("done8_result", {29'd0, bus8.eq, bus8.lt, bus8.gt}, {29'd0, e.res});
                check("done8_busy", {31'd0, bus8.busy}, 32'd0);
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus1.done) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done1_unexpected actual=%b required=no_done at edge %0d",
                         {bus1.eq, bus1.lt, bus1.gt}, cyc);
            end else begin
                e = q1.pop_front();
                check("done1_edge", cyc, e.at);
                check("done1_result", {29'd0, bus1.eq, bus1.lt, bus1.gt}, {29'd0, e.res});
            end
        end
    end

    function automatic logic [4:0] outs8();
        return {bus8.busy, bus8.done, bus8.eq, bus8.lt, bus8.gt};
    endfunction

    // Present operands for one edge; operands are scrambled afterwards to prove they were latched.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, output int unsigned acc);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk);
        #1;
        acc        = cyc;
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
    endtask

    task automatic launch1(input logic a, input logic b, output int unsigned acc);
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.a     = a;
        bus1.b     = b;
        @(posedge clk);
        #1;
        acc        = cyc;
        bus1.start = 1'b0;
        bus1.a     = ~a;
        bus1.b     = ~b;
    endtask

    task automatic wait_idle8(input string name, input int budget);
        int n = 0;
        while ((q8.size() != 0 || bus8.busy || bus8.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= budget) check({name, "_timeout"}, n, 0);
    endtask

    task automatic wait_idle1(input string name, input int budget);
        int n = 0;
        while ((q1.size() != 0 || bus1.busy || bus1.done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (n >= budget) check({name, "_timeout"}, n, 0);
    endtask

    initial begin
        int unsigned acc;
        logic [2:0]  w1_exp [4];
        w1_exp[0] = 3'b100;
        w1_exp[1] = 3'b010;
        w1_exp[2] = 3'b001;
        w1_exp[3] = 3'b100;

        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;

        // Reset then idle.
        repeat (3) @(negedge clk);
        check("reset_outs", {27'd0, outs8()}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outs", {27'd0, outs8()}, 32'd0);
        end

        // 0x80 vs 0x7F: decided at the MSB.
        launch8(8'h80, 8'h7F, acc);
        q8.push_back('{acc + 1, 3'b001});
        check("busy_80", {31'd0, bus8.busy}, 32'd1);
        wait_idle8("cmp_80", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_gt", {27'd0, outs8()}, 32'b00001);
        end

        // 0x12 vs 0x13: differs only at bit 0, full walk.
        launch8(8'h12, 8'h13, acc);
        q8.push_back('{acc + 8, 3'b010});
        repeat (7) @(posedge clk);
        #1;
        check("busy_late_12", {27'd0, outs8()}, 32'b10000);
        wait_idle8("cmp_12", 20);
        check("hold_lt", {27'd0, outs8()}, 32'b00010);

        // Equal operands.
        launch8(8'hA5, 8'hA5, acc);
        q8.push_back('{acc + 8, 3'b100});
        wait_idle8("cmp_a5", 20);
        check("hold_eq", {27'd0, outs8()}, 32'b00100);

        // Start requests while busy and in DONE are dropped.
        launch8(8'h01, 8'h00, acc);
        q8.push_back('{acc + 8, 3'b001});
        while (cyc < acc + 2) @(negedge clk);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
        @(negedge clk);
        bus8.start = 1'b0;
        while (cyc < acc + 8) @(negedge clk);
        check("done_seen_01", {31'd0, bus8.done}, 32'd1);
        bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'h00;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ignored_start", {27'd0, outs8()}, 32'b00001);
            @(negedge clk);
        end
        check("queue8_empty", q8.size(), 0);

        // Asynchronous reset clears held results without a clock edge.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_clear", {27'd0, outs8()}, 32'd0);
        #1 rst = 1'b0;

        // Reset mid-compare aborts with no done pulse.
        launch8(8'h00, 8'h00, acc);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 check("abort_busy", {27'd0, outs8()}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_quiet", {27'd0, outs8()}, 32'd0);
        end
        launch8(8'h00, 8'h00, acc);
        q8.push_back('{acc + 8, 3'b100});
        wait_idle8("cmp_after_abort", 20);

        // WIDTH=1 instance: every operand pair completes after one SHIFT cycle.
        for (int p = 0; p < 4; p++) begin
            logic [1:0] ab;
            ab = 2'(p);
            launch1(ab[1], ab[0], acc);
            q1.push_back('{acc + 1, w1_exp[p]});
            wait_idle1("cmp_w1", 10);
        end
        check("queue1_empty", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=finish_before_limit", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_mag_cmp_ctrl.md
Name: serial_mag_cmp_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit magnitude compare by stepping a 1-bit comparator cell MSB-first over latched operands, one bit per clock. It exits early at the first differing bit. Start/done handshake allows a bus master or test sequencer to launch compares and read one-hot eq/lt/gt results. It sits between operand registers and any consumer that needs a registered compare result at low area cost.

Parameters:
WIDTH, 8, operand width in bits (legal range ≥1)

Ports:
clk  input  1  single system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a compare; sampled only in IDLE
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
busy  output  1  high while bits are being compared (SHIFT state)
done  output  1  one-cycle pulse; results valid from this cycle
eq  output  1  A == B (registered, held)
lt  output  1  A < B, unsigned (registered, held)
gt  output  1  A > B, unsigned (registered, held)

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, eq=0, lt=0, gt=0; operand regs and index=0. Assertion mid-compare aborts immediately. No done pulse is produced for the aborted compare.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE: if start=1 at edge, latch a→ra and b→rb, set idx=WIDTH-1, clear eq/lt/gt to 0, set busy=1, go to SHIFT. Otherwise hold state and previous results.
- SHIFT: each cycle, the cell compares ra[idx] and rb[idx].
  - ra[idx]>rb[idx]: gt=1, busy=0, done=1, go to DONE.
  - ra[idx]<rb[idx]: lt=1, busy=0, done=1, go to DONE.
  - Bits equal and idx==0: eq=1, busy=0, done=1, go to DONE.
  - Bits equal and idx>0: idx=idx-1, stay in SHIFT.
- DONE: lasts exactly one cycle. Deassert done and return to IDLE. start is ignored in DONE.
- Latency: start accepted at edge N. SHIFT occupies cycles N+1 .. N+(WIDTH-k), where k is the highest differing bit index (k=0 if equal). done is high in cycle N+(WIDTH-k)+1. Best case is 2 cycles; worst case (equal, or differing only at bit 0) is WIDTH+1 cycles.
- start while busy or in DONE: ignored. Operands are not re-sampled, and the in-flight compare is unaffected.
- Input changes on a/b after acceptance have no effect.
- Invariant: after the first completed compare, exactly one of eq/lt/gt is 1 outside SHIFT. All three are 0 during SHIFT and after reset.
- idx width: clog2(WIDTH), minimum 1 bit. It never underflows, because the idx==0 path always exits.
- WIDTH=1: a single SHIFT cycle always completes.

Decomposition:
- Shared package cmp_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - result encoding constants (RES_EQ, RES_LT, RES_GT) for future consumers
- Sub-module mag_bit_cell: purely combinational 1-bit comparator with inputs x, y and outputs eq, lt, gt. Instantiated once in the controller and driven by ra[idx], rb[idx].
- Controller holds the FSM, index counter, operand and result registers.

Test Plan:
- Reset then idle (rst pulse, start=0) → busy=done=eq=lt=gt=0 for 10 cycles. Assert rst asynchronously between edges → outputs clear without waiting for clk.
- a=8'h80, b=8'h7F, start at edge N → busy high 1 cycle; done=1 and gt=1 at cycle N+2; eq=lt=0; gt held through 5 idle cycles.
- a=8'h12, b=8'h13 → 8 SHIFT cycles; done and lt=1 at N+9. a=8'hA5, b=8'hA5 → eq=1 at N+9.
- Start during compare: launch a=8'h01, b=8'h00. Assert start with a=8'hFF, b=8'h00 at cycles N+3 and at the DONE cycle → first result gt at N+9. Only one done pulse; the second start is not accepted until IDLE.
- Reset mid-op: launch a=8'h00, b=8'h00 and assert rst at N+4 → busy=0 immediately, no done. A new start after release produces eq=1 with full 9-cycle latency.
- WIDTH=1 instance: all four (a,b) pairs → done at N+2 with eq/lt/gt = 100, 010, 001, 100 for 00, 01, 10, 11.
